// File: rtl/div_bcd_conv.sv
// Binary-to-BCD converter for the divider's quotient and remainder.
// Both operands are converted in parallel by shift-and-add-3 lanes stepped by a small FSM.

module div_bcd_lane #(
    parameter int N = 6
) (
    input  logic [7:0]   bcd,
    input  logic [N-1:0] bin,
    output logic [7:0]   bcd_nx,
    output logic [N-1:0] bin_nx
);
    logic [3:0] tens_a, ones_a;

    always_comb begin
        tens_a = (bcd[7:4] >= 4'd5) ? 4'(bcd[7:4] + 4'd3) : bcd[7:4];
        ones_a = (bcd[3:0] >= 4'd5) ? 4'(bcd[3:0] + 4'd3) : bcd[3:0];
        // Tens never exceeds 6 for a 6-bit operand, so the adjusted tens MSB is dropped.
        bcd_nx = 8'({tens_a, ones_a, bin[N-1]});
        bin_nx = {bin[N-2:0], 1'b0};
    end
endmodule

module div_bcd_conv #(
    parameter int N = 6
) (
    input  logic         CLK,
    input  logic         CLR_N,
    input  logic [N-1:0] Q,
    input  logic [N-1:0] R,
    input  logic         START,
    output logic         BUSY,
    output logic         DONE,
    output logic         VALID,
    output logic [3:0]   Q_TENS,
    output logic [3:0]   Q_ONES,
    output logic [3:0]   R_TENS,
    output logic [3:0]   R_ONES
);
    localparam int LANES = 2;

    typedef enum logic [1:0] {
        st_IDLE  = 2'd0,
        st_SHIFT = 2'd1,
        st_DONE  = 2'd2
    } state_t;

    state_t                       state;
    logic [2:0]                   cnt;
    logic [LANES-1:0][N-1:0]      bin_r, bin_nx;
    logic [LANES-1:0][7:0]        bcd_r, bcd_nx;

    // Lane 0 converts the quotient, lane 1 the remainder.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        div_bcd_lane #(.N(N)) u_lane (
            .bcd    (bcd_r[g]),
            .bin    (bin_r[g]),
            .bcd_nx (bcd_nx[g]),
            .bin_nx (bin_nx[g])
        );
    end

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            state  <= st_IDLE;
            cnt    <= '0;
            bin_r  <= '0;
            bcd_r  <= '0;
            BUSY   <= 1'b0;
            DONE   <= 1'b0;
            VALID  <= 1'b0;
            Q_TENS <= 4'h0;
            Q_ONES <= 4'h0;
            R_TENS <= 4'h0;
            R_ONES <= 4'h0;
        end else begin
            case (state)
                st_IDLE: begin
                    DONE <= 1'b0;
                    if (START) begin
                        bin_r <= {R, Q};
                        bcd_r <= '0;
                        cnt   <= '0;
                        VALID <= 1'b0;
                        BUSY  <= 1'b1;
                        state <= st_SHIFT;
                    end
                end
                st_SHIFT: begin
                    bin_r <= bin_nx;
                    bcd_r <= bcd_nx;
                    cnt   <= cnt + 3'd1;
                    // Digits load from the final shift's result so they appear with DONE.
                    if (cnt == 3'(N-1)) begin
                        BUSY   <= 1'b0;
                        DONE   <= 1'b1;
                        VALID  <= 1'b1;
                        Q_TENS <= bcd_nx[0][7:4];
                        Q_ONES <= bcd_nx[0][3:0];
                        R_TENS <= bcd_nx[1][7:4];
                        R_ONES <= bcd_nx[1][3:0];
                        state  <= st_DONE;
                    end
                end
                st_DONE: begin
                    DONE  <= 1'b0;
                    state <= st_IDLE;
                end
                default: begin
                    BUSY  <= 1'b0;
                    DONE  <= 1'b0;
                    state <= st_IDLE;
                end
            endcase
        end
    end
endmodule
